seq_multiplier: RTL



---
 rtl/seq_multiplier_pkg.sv | 9 +
 rtl/seq_multiplier_adder.sv | 41 ++++
 rtl/seq_multiplier.sv | 116 +++++++++++
 3 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared types and width constants for the sequential shift-and-add multiplier.
package seq_mul_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int MUL_W     = 16;
  localparam int MUL_STEPS = 16;
  localparam int CNT_W     = 5;
  localparam int PROD_W    = 2 * MUL_W;
endpackage

// File: rtl/seq_multiplier_adder.sv
// 16-bit two-level carry-lookahead adder (4-bit groups); overflow is the unsigned carry-out.
module adder
  import seq_mul_pkg::*;
(
  input  logic [MUL_W-1:0] a,
  input  logic [MUL_W-1:0] b,
  output logic [MUL_W-1:0] sum,
  output logic             overflow
);
  localparam int GROUPS = MUL_W / 4;

  // Carry into each of four bit positions, given the carry into position 0.
  function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic cin);
    logic [3:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  function automatic logic gen4(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  logic [MUL_W-1:0]  bit_g, bit_p, carry;
  logic [GROUPS-1:0] grp_g, grp_p, grp_c;

  assign bit_g = a & b;
  assign bit_p = a ^ b;

  for (genvar k = 0; k < GROUPS; k++) begin : g_grp
    assign grp_g[k]          = gen4(bit_g[4*k +: 4], bit_p[4*k +: 4]);
    assign grp_p[k]          = &bit_p[4*k +: 4];
    assign carry[4*k +: 4]   = cla4(bit_g[4*k +: 4], bit_p[4*k +: 4], grp_c[k]);
  end

  assign grp_c    = cla4(grp_g, grp_p, 1'b0);
  assign overflow = gen4(grp_g, grp_p);
  assign sum      = bit_p ^ carry;
endmodule

// File: rtl/seq_multiplier.sv
// Sequential 16x16 shift-and-add multiplier with valid/ready handshakes on both sides.
// Define SEQ_MUL_SIGNED_EN for two's-complement operands and product.
module seq_multiplier
  import seq_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MUL_W-1:0]  a,
  input  logic [MUL_W-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product
);
  state_t           state_q, state_d;
  logic [MUL_W-1:0] mcand_q, mcand_d;
  logic [MUL_W-1:0] acc_hi_q, acc_hi_d;
  logic [MUL_W-1:0] acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MUL_W-1:0] add_sum, step_s;
  logic             add_carry, step_c;

  adder u_adder (
    .a        (acc_hi_q),
    .b        (mcand_q),
    .sum      (add_sum),
    .overflow (add_carry)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);

`ifdef SEQ_MUL_SIGNED_EN
  logic neg_q, neg_d;

  // |-32768| wraps to 0x8000, which is the correct unsigned magnitude.
  function automatic logic [MUL_W-1:0] mag(input logic [MUL_W-1:0] v);
    return v[MUL_W-1] ? (~v + MUL_W'(1)) : v;
  endfunction

  logic [PROD_W-1:0] raw_prod;
  assign raw_prod = {acc_hi_q, acc_lo_q};
  assign product  = neg_q ? (~raw_prod + PROD_W'(1)) : raw_prod;
`else
  assign product = {acc_hi_q, acc_lo_q};
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
`ifdef SEQ_MUL_SIGNED_EN
    neg_d    = neg_q;
`endif
    step_c = 1'b0;
    step_s = acc_hi_q;
    if (acc_lo_q[0]) begin
      step_c = add_carry;
      step_s = add_sum;
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
`ifdef SEQ_MUL_SIGNED_EN
          mcand_d  = mag(a);
          acc_lo_d = mag(b);
          neg_d    = a[MUL_W-1] ^ b[MUL_W-1];
`else
          mcand_d  = a;
          acc_lo_d = b;
`endif
          acc_hi_d = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // Multiplier bits retire from acc_lo's LSB while product bits fill its MSB.
        acc_hi_d = {step_c, step_s[MUL_W-1:1]};
        acc_lo_d = {step_s[0], acc_lo_q[MUL_W-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_STEPS - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
`ifdef SEQ_MUL_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end
endmodule
